// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and the default byte width
// used by the receiver, transmitter and arbiter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: the first set request after rr_ptr
// (wrapping modulo NUM_REQ) wins.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               any,
    output logic [IDW-1:0]     winner
);
    localparam int SW = IDW + 1;
    localparam logic [SW-1:0] NUM_REQ_W = SW'(NUM_REQ);

    logic [IDW-1:0]     cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand[gi] is the requester at search distance gi+1 from rr_ptr
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SW-1:0] sum;
        assign sum      = {1'b0, rr_ptr} + SW'(gi + 1);
        assign cand[gi] = IDW'((sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        any    = |hit;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) winner = cand[i];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ
// requesters; a grant is held for a whole packet or until a valid-low timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic                         grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         timeout_evt
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t        state_reg, state_next;
    logic [IDW-1:0]    grant_id_reg, grant_id_next;
    logic              grant_valid_reg, grant_valid_next;
    logic [IDW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [DATA_W-1:0] tx_data_reg, tx_data_next;
    logic              tx_start_reg, tx_start_next;
    logic              last_reg, last_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic              pick_any;
    logic [IDW-1:0]    pick_winner;
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_reg),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign sel_valid = req_valid[grant_id_reg];
    assign sel_last  = req_last[grant_id_reg];
    assign sel_data  = data_arr[grant_id_reg];

    always_comb begin
        state_next       = state_reg;
        grant_id_next    = grant_id_reg;
        grant_valid_next = grant_valid_reg;
        rr_ptr_next      = rr_ptr_reg;
        tx_data_next     = tx_data_reg;
        tx_start_next    = 1'b0;
        last_next        = last_reg;
        cnt_next         = cnt_reg;
        req_ready        = '0;
        timeout_evt      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_id_next    = pick_winner;
                    grant_valid_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = ISSUE;
                end
            end
            ISSUE: begin
                req_ready[grant_id_reg] = !tx_busy;
                if (sel_valid && !tx_busy) begin
                    tx_data_next  = sel_data;
                    last_next     = sel_last;
                    tx_start_next = 1'b1;
                    cnt_next      = '0;
                    state_next    = WAIT;
                end else if (!sel_valid) begin
                    // An accepted byte takes priority over an expiring timeout.
                    if ((TIMEOUT != 0) && (cnt_reg == CNT_MAX)) begin
                        timeout_evt      = 1'b1;
                        rr_ptr_next      = grant_id_reg;
                        grant_valid_next = 1'b0;
                        state_next       = IDLE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (last_reg) begin
                        rr_ptr_next      = grant_id_reg;
                        grant_valid_next = 1'b0;
                        state_next       = IDLE;
                    end else begin
                        cnt_next   = '0;
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_id_reg    <= '0;
            grant_valid_reg <= 1'b0;
            rr_ptr_reg      <= IDW'(NUM_REQ - 1);
            tx_data_reg     <= '0;
            tx_start_reg    <= 1'b0;
            last_reg        <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            grant_id_reg    <= grant_id_next;
            grant_valid_reg <= grant_valid_next;
            rr_ptr_reg      <= rr_ptr_next;
            tx_data_reg     <= tx_data_next;
            tx_start_reg    <= tx_start_next;
            last_reg        <= last_next;
            cnt_reg         <= cnt_next;
        end
    end

    assign tx_start    = tx_start_reg;
    assign tx_data     = tx_data_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_id    = grant_id_reg;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART byte transmitter among NUM_REQ requesters. Each requester presents bytes on a valid/ready handshake, and a grant is held for a whole packet, ending at the byte flagged last. The block sits between client logic (command responders, debug/log sources) and the UART transmitter. It drives that transmitter with a one-cycle start pulse and waits for its done pulse before issuing the next byte.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- DATA_W, default 8: byte width.
- TIMEOUT, default 1023: cycles a granted requester may drop req_valid mid-packet before the grant is revoked; 0 disables.

- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  input  NUM_REQ  byte is last of packet
- req_ready  output  NUM_REQ  per-requester accept; combinational from state, grant_id and tx_busy
- tx_start  output  1  one-cycle start pulse to transmitter
- tx_data  output  DATA_W  byte to transmit, held stable until next load
- tx_busy  input  1  transmitter busy
- tx_done  input  1  one-cycle pulse: byte fully shifted out (stop bit complete)
- grant_valid  output  1  a requester currently holds the grant
- grant_id  output  $clog2(NUM_REQ)  current/last grant owner
- timeout_evt  output  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- Reset values: every output 0, state IDLE, rr_ptr = NUM_REQ-1 (so requester 0 wins first), timeout counter 0.
- Arbitration:
  - Winner is the first i with req_valid[i] set, searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - rr_ptr updates to grant_id only when a grant is released, either by the last byte or by timeout.
- FSM:
  - IDLE: if any req_valid, go to ISSUE with grant_id <= winner and grant_valid <= 1.
  - ISSUE:
    - req_ready[grant_id] = !tx_busy; all other req_ready bits are 0.
    - On req_valid[grant_id] && !tx_busy: tx_data <= byte, last_r <= req_last[grant_id], tx_start <= 1 on the next cycle, go to WAIT.
    - While req_valid[grant_id] is low, the timeout counter increments. When it reaches TIMEOUT: timeout_evt pulse, rr_ptr <= grant_id, grant_valid <= 0, go to IDLE.
  - WAIT: req_ready all 0. On tx_done:
    - if last_r: rr_ptr <= grant_id, grant_valid <= 0, go to IDLE;
    - else go to ISSUE.
- The timeout counter clears on every accepted byte and on entry to ISSUE.
- Only requesters with req_valid high are considered; changes on non-granted inputs are ignored while a grant is held.

## Timing
- IDLE to transmit:
  - req_valid rises in cycle 0 (IDLE).
  - grant_valid and req_ready are high in cycle 1.
  - The handshake completes in cycle 1 if tx_busy is 0.
  - tx_start is high in cycle 2, together with the new tx_data.
- tx_done sampled in cycle k: ISSUE in cycle k+1 (next byte may handshake in k+1, tx_start in k+2). On a last byte: IDLE in k+1, next grant in k+2.
- tx_busy is ignored in WAIT. A tx_done seen outside WAIT is ignored.
- A tx_done in the same cycle as tx_start is not possible (transmitter latency is at least 1 frame); no special handling is required.
- Timeout and handshake in the same cycle: the handshake wins and the counter clears.
- Reset asserted mid-packet: the FSM returns to IDLE immediately. tx_start deasserts and nothing is retransmitted; the interrupted byte on the line is the transmitter's concern.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Structure
- Shared package uart_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT);
  - UART_DATA_W = 8, reused by the receiver/transmitter.
- Sub-module uart_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, winner index.
  - Instantiated once.

## Test plan
- Single requester: requester 2 sends a 3-byte packet 0x41, 0x42, 0x43 (last on 0x43). Expect exactly 3 tx_start pulses, each one cycle after its handshake. grant_id = 2 throughout; grant_valid drops in the cycle after the third tx_done.
- Fairness: all 4 requesters hold 1-byte packets continuously from reset. Expect grant order 0, 1, 2, 3, 0, 1, … with no requester granted twice before the others.
- Packet lock: requester 0 sends a 4-byte packet while requester 1 is valid throughout. Expect all 4 bytes from requester 0 before any grant to 1; req_ready[1] stays 0 the whole time.
- Backpressure: tx_busy held at 1 in ISSUE for 5 cycles. Expect req_ready 0 and no tx_start during those cycles; the handshake occurs in the first cycle tx_busy is 0.
- Timeout: with TIMEOUT = 8, requester 1 drops valid after byte 1 of a 2-byte packet. Expect a timeout_evt pulse 8 cycles into ISSUE, grant_valid 0 in the next cycle, and requester 2 granted next.
- Reset mid-WAIT: assert rst while a byte is in flight. Expect all outputs 0 and state IDLE. After reset releases, requester 0 wins first even if requester 3 was previously granted.
